// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor
//   Watches the hsync/vsync/rgb stream of a VGA sync generator, recovers the
//   pixel coordinate of every sample, and checks line/frame timing. Timing
//   checks drive a SEARCH -> ALIGN -> LOCKED state machine; a failed check
//   while checking is enabled raises a sticky error flag and drops lock.
//
// Ports
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_tick              pixel enable; everything advances only when high
//   i_hsync, i_vsync    active-high sync pulses from the generator
//   i_rgb[2:0]          pixel colour
//   i_err_clr           clears the sticky error flags (a new error wins)
//   o_pixel_x/y[9:0]    recovered coordinate of the last sample
//   o_video_on          locked and inside the active area
//   o_rgb_out[2:0]      sampled colour inside the active area, else 0
//   o_pix_valid         one-clock pulse per sample
//   o_locked            state machine is LOCKED
//   o_err_line/hs/frame/vs  sticky timing errors
//   o_frame_count[7:0]  vsync rises seen while locked (mod 256)
module vga_sync_monitor #(
    parameter int H_DISP       = 640,
    parameter int H_TOTAL      = 800,
    parameter int H_SYNC       = 96,
    parameter int H_SYNC_START = 656,
    parameter int V_DISP       = 480,
    parameter int V_TOTAL      = 525,
    parameter int V_SYNC       = 2,
    parameter int V_SYNC_START = 490
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_tick,
    input  logic       i_hsync,
    input  logic       i_vsync,
    input  logic [2:0] i_rgb,
    input  logic       i_err_clr,
    output logic [9:0] o_pixel_x,
    output logic [9:0] o_pixel_y,
    output logic       o_video_on,
    output logic [2:0] o_rgb_out,
    output logic       o_pix_valid,
    output logic       o_locked,
    output logic       o_err_line,
    output logic       o_err_hs,
    output logic       o_err_frame,
    output logic       o_err_vs,
    output logic [7:0] o_frame_count
);
    localparam logic [9:0] HD  = 10'(H_DISP);
    localparam logic [9:0] HT1 = 10'(H_TOTAL - 1);
    localparam logic [9:0] HSW = 10'(H_SYNC);
    localparam logic [9:0] HS0 = 10'(H_SYNC_START);
    localparam logic [9:0] VD  = 10'(V_DISP);
    localparam logic [9:0] VT  = 10'(V_TOTAL);
    localparam logic [9:0] VT1 = 10'(V_TOTAL - 1);
    localparam logic [9:0] VSW = 10'(V_SYNC);
    localparam logic [9:0] VS0 = 10'(V_SYNC_START);

    typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;
    state_t r_state;

    logic       r_hs, r_vs;           // previous sync samples
    logic [9:0] r_hcnt;               // ticks since last hsync rise, minus one
    logic [9:0] r_hhigh;              // ticks hsync has been high
    logic [9:0] r_vcnt;               // hsync rises since last vsync rise
    logic [9:0] r_vhigh;              // hsync rises while vsync high
    logic       r_h_meas, r_v_meas;   // a rise has been seen, so counts are real

    // Counters stick at 1023 so an overlong interval can never alias onto
    // the expected value.
    function automatic logic [9:0] sat_inc(input logic [9:0] v, input logic en);
        return (en && v != 10'h3FF) ? v + 10'd1 : v;
    endfunction

    logic       w_hs_rise, w_hs_fall, w_vs_rise, w_vs_fall;
    logic       w_x_wrap;
    logic [9:0] w_x_nxt, w_y_nxt, w_vcnt_inc;
    logic       w_fail_line, w_fail_hs, w_fail_frame, w_fail_vs, w_fail_any;
    logic       w_chk_en, w_lock_nxt, w_vid_nxt;

    assign w_hs_rise = i_hsync & ~r_hs;
    assign w_hs_fall = ~i_hsync & r_hs;
    assign w_vs_rise = i_vsync & ~r_vs;
    assign w_vs_fall = ~i_vsync & r_vs;

    assign w_x_wrap = ~w_hs_rise & (o_pixel_x == HT1);
    assign w_x_nxt  = w_hs_rise ? HS0 : (w_x_wrap ? 10'd0 : o_pixel_x + 10'd1);
    assign w_y_nxt  = w_vs_rise ? VS0 :
                      w_x_wrap  ? ((o_pixel_y == VT1) ? 10'd0 : o_pixel_y + 10'd1) :
                                  o_pixel_y;

    // A vsync rise coinciding with an hsync rise counts that line in the
    // frame that is ending.
    assign w_vcnt_inc   = sat_inc(r_vcnt, w_hs_rise);
    assign w_fail_line  = r_h_meas & w_hs_rise & (r_hcnt != HT1);
    assign w_fail_hs    = r_h_meas & w_hs_fall & (r_hhigh != HSW);
    assign w_fail_frame = r_v_meas & w_vs_rise & (w_vcnt_inc != VT);
    assign w_fail_vs    = r_v_meas & w_vs_fall & (r_vhigh != VSW);
    assign w_fail_any   = w_fail_line | w_fail_hs | w_fail_frame | w_fail_vs;
    assign w_chk_en     = (r_state != SEARCH);

    // Lock as it will stand after this sample; gates video in the same edge.
    assign w_lock_nxt = ~w_fail_any &
                        (((r_state == ALIGN) & w_vs_rise) | (r_state == LOCKED));
    assign w_vid_nxt  = w_lock_nxt & (w_x_nxt < HD) & (w_y_nxt < VD);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= SEARCH;
            o_locked      <= 1'b0;
            o_frame_count <= 8'd0;
        end else if (i_tick) begin
            o_locked <= w_lock_nxt;
            case (r_state)
                SEARCH: if (w_vs_rise) r_state <= ALIGN;
                ALIGN: begin
                    if (w_fail_any)     r_state <= SEARCH;
                    else if (w_vs_rise) r_state <= LOCKED;
                end
                LOCKED: begin
                    if (w_fail_any)     r_state <= SEARCH;
                    else if (w_vs_rise) o_frame_count <= o_frame_count + 8'd1;
                end
                default: r_state <= SEARCH;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_hs        <= 1'b0;
            r_vs        <= 1'b0;
            o_pixel_x   <= 10'd0;
            o_pixel_y   <= 10'd0;
            o_video_on  <= 1'b0;
            o_rgb_out   <= 3'd0;
            o_pix_valid <= 1'b0;
            r_hcnt      <= 10'd0;
            r_hhigh     <= 10'd0;
            r_vcnt      <= 10'd0;
            r_vhigh     <= 10'd0;
            r_h_meas    <= 1'b0;
            r_v_meas    <= 1'b0;
            o_err_line  <= 1'b0;
            o_err_hs    <= 1'b0;
            o_err_frame <= 1'b0;
            o_err_vs    <= 1'b0;
        end else begin
            o_pix_valid <= i_tick;
            // Clear acts every clock; a failure on the same edge still sets.
            o_err_line  <= (o_err_line  & ~i_err_clr) | (i_tick & w_chk_en & w_fail_line);
            o_err_hs    <= (o_err_hs    & ~i_err_clr) | (i_tick & w_chk_en & w_fail_hs);
            o_err_frame <= (o_err_frame & ~i_err_clr) | (i_tick & w_chk_en & w_fail_frame);
            o_err_vs    <= (o_err_vs    & ~i_err_clr) | (i_tick & w_chk_en & w_fail_vs);
            if (i_tick) begin
                r_hs       <= i_hsync;
                r_vs       <= i_vsync;
                o_pixel_x  <= w_x_nxt;
                o_pixel_y  <= w_y_nxt;
                o_video_on <= w_vid_nxt;
                o_rgb_out  <= w_vid_nxt ? i_rgb : 3'd0;
                r_hcnt     <= w_hs_rise ? 10'd0 : sat_inc(r_hcnt, 1'b1);
                r_hhigh    <= w_hs_rise ? 10'd1 : sat_inc(r_hhigh, i_hsync);
                r_vcnt     <= w_vs_rise ? 10'd0 : w_vcnt_inc;
                r_vhigh    <= w_vs_rise ? {9'd0, w_hs_rise}
                                        : sat_inc(r_vhigh, i_vsync & w_hs_rise);
                if (w_hs_rise) r_h_meas <= 1'b1;
                if (w_vs_rise) r_v_meas <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_vga_sync_monitor.sv
// Bench for vga_sync_monitor on a shrunken raster (24x10 ticks/lines) so many
// frames fit in a short run. A timestamp-based reference model is compared
// against every output on every clock; directed scenarios add literal checks.
module tb_vga_sync_monitor;
    localparam int HD = 16, HT = 24, HS = 4, HS0 = 18;
    localparam int VD = 6,  VT = 10, VS = 2, VS0 = 7;
    localparam int GAP = 4;

    logic       clk = 1'b0;
    logic       reset, tick, hsync, vsync, err_clr;
    logic [2:0] rgb;
    logic [9:0] pixel_x, pixel_y;
    logic       video_on, pix_valid, locked;
    logic       err_line, err_hs, err_frame, err_vs;
    logic [2:0] rgb_out;
    logic [7:0] frame_count;

    always #5 clk = ~clk;

    vga_sync_monitor #(
        .H_DISP(HD), .H_TOTAL(HT), .H_SYNC(HS), .H_SYNC_START(HS0),
        .V_DISP(VD), .V_TOTAL(VT), .V_SYNC(VS), .V_SYNC_START(VS0)
    ) dut (
        .i_clk(clk), .i_reset(reset), .i_tick(tick), .i_hsync(hsync),
        .i_vsync(vsync), .i_rgb(rgb), .i_err_clr(err_clr),
        .o_pixel_x(pixel_x), .o_pixel_y(pixel_y), .o_video_on(video_on),
        .o_rgb_out(rgb_out), .o_pix_valid(pix_valid), .o_locked(locked),
        .o_err_line(err_line), .o_err_hs(err_hs), .o_err_frame(err_frame),
        .o_err_vs(err_vs), .o_frame_count(frame_count)
    );

    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int        m_x = 0, m_y = 0, m_state = 0, m_fc = 0;
    bit        m_locked = 0, m_vo = 0, m_pv = 0;
    bit        m_el = 0, m_eh = 0, m_ef = 0, m_ev = 0, m_phs = 0, m_pvs = 0;
    bit        m_have_vr = 0;
    logic [2:0] m_rgb = 0;
    longint    m_n = 0, m_last_hr = -1;
    int        m_htot = 0, m_h_at_vs = 0, m_h_at_vsr = 0;

    always @(posedge clk) begin : mdl
        bit hr, hf, vr, vf, fl, fh, ff, fv, any, en, wrap;
        bit sl, sh, sf, sv;
        int hpre, hpost;
        sl = 0; sh = 0; sf = 0; sv = 0;
        if (reset) begin
            m_x = 0; m_y = 0; m_state = 0; m_fc = 0; m_locked = 0; m_vo = 0;
            m_pv = 0; m_el = 0; m_eh = 0; m_ef = 0; m_ev = 0; m_phs = 0;
            m_pvs = 0; m_have_vr = 0; m_rgb = 0; m_n = 0; m_last_hr = -1;
            m_htot = 0; m_h_at_vs = 0; m_h_at_vsr = 0;
        end else begin
            if (tick) begin
                m_n++;
                hr = hsync && !m_phs;  hf = !hsync && m_phs;
                vr = vsync && !m_pvs;  vf = !vsync && m_pvs;
                hpre  = m_htot;
                hpost = m_htot + int'(hr);
                fl = hr && m_last_hr >= 0 && (m_n - m_last_hr != HT);
                fh = hf && m_last_hr >= 0 && (m_n - m_last_hr != HS);
                ff = vr && m_have_vr && (hpost - m_h_at_vs != VT);
                fv = vf && m_have_vr && (hpre - m_h_at_vsr != VS);
                any = fl || fh || ff || fv;
                en  = (m_state != 0);
                sl = en && fl; sh = en && fh; sf = en && ff; sv = en && fv;
                if (hr) begin m_htot = hpost; m_last_hr = m_n; end
                if (vr) begin m_h_at_vs = hpost; m_h_at_vsr = hpre; m_have_vr = 1; end
                case (m_state)
                    0: if (vr) m_state = 1;
                    1: if (any) m_state = 0; else if (vr) m_state = 2;
                    default: if (any) m_state = 0; else if (vr) m_fc = (m_fc + 1) % 256;
                endcase
                m_locked = (m_state == 2);
                wrap = !hr && (m_x == HT - 1);
                m_x  = hr ? HS0 : (m_x + 1) % HT;
                if (vr)        m_y = VS0;
                else if (wrap) m_y = (m_y + 1) % VT;
                m_vo  = m_locked && m_x < HD && m_y < VD;
                m_rgb = m_vo ? rgb : 3'd0;
                m_phs = hsync; m_pvs = vsync; m_pv = 1;
            end else begin
                m_pv = 0;
            end
            m_el = (m_el && !err_clr) || sl;
            m_eh = (m_eh && !err_clr) || sh;
            m_ef = (m_ef && !err_clr) || sf;
            m_ev = (m_ev && !err_clr) || sv;
        end
        #1;
        chk("pixel_x", pixel_x, m_x);
        chk("pixel_y", pixel_y, m_y);
        chk("video_on", video_on, m_vo);
        chk("rgb_out", rgb_out, m_rgb);
        chk("pix_valid", pix_valid, m_pv);
        chk("locked", locked, m_locked);
        chk("err_line", err_line, m_el);
        chk("err_hs", err_hs, m_eh);
        chk("err_frame", err_frame, m_ef);
        chk("err_vs", err_vs, m_ev);
        chk("frame_count", frame_count, m_fc);
    end

    // ---------------- stimulus ----------------
    int hs_w = HS, vs_w = VS;

    function automatic bit hs_at(input int x);
        return x >= HS0 && x < HS0 + hs_w;
    endfunction
    function automatic bit vs_at(input int y);
        return y >= VS0 && y < VS0 + vs_w;
    endfunction

    // One sample: tick high for one clock, then GAP-1 idle clocks.
    task automatic do_tick(input bit hs, input bit vs, input bit clr);
        @(negedge clk);
        tick = 1; hsync = hs; vsync = vs; rgb = 3'b101; err_clr = clr;
        @(posedge clk); #1;
        for (int k = 1; k < GAP; k++) begin
            @(negedge clk); tick = 0; err_clr = 0;
            @(posedge clk); #1;
        end
    endtask

    task automatic run(input int y, input int x0, input int x1);
        for (int x = x0; x <= x1; x++) do_tick(hs_at(x), vs_at(y), 1'b0);
    endtask

    task automatic lines(input int y0, input int y1);
        for (int y = y0; y <= y1; y++) run(y, 0, HT - 1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(negedge clk); tick = 0; err_clr = 0; end
        @(posedge clk); #1;
    endtask

    task automatic clr_pulse();
        @(negedge clk); err_clr = 1;
        @(negedge clk); err_clr = 0;
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog expired checks=%0d", checks);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        reset = 1; tick = 0; hsync = 0; vsync = 0; rgb = 0; err_clr = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_px", pixel_x, 0);
        chk("rst_py", pixel_y, 0);
        chk("rst_locked", locked, 0);
        chk("rst_fc", frame_count, 0);
        chk("rst_pv", pix_valid, 0);
        @(negedge clk); reset = 0;

        // F0: first vsync rise only starts alignment
        lines(0, 6); run(7, 0, 0);
        chk("f0_px", pixel_x, 0); chk("f0_py", pixel_y, 7); chk("f0_locked", locked, 0);
        run(7, 1, HT - 1); lines(8, 9);
        // F1: second vsync rise locks
        lines(0, 6); run(7, 0, 0);
        chk("f1_locked", locked, 1); chk("f1_fc", frame_count, 0);
        run(7, 1, HT - 1); lines(8, 9);
        // F2: active-area edge and third vsync rise
        lines(0, 4); run(5, 0, 15);
        chk("f2_vo_in", video_on, 1); chk("f2_rgb_in", rgb_out, 5);
        chk("f2_px", pixel_x, 15); chk("f2_py", pixel_y, 5);
        run(5, 16, 16);
        chk("f2_vo_edge", video_on, 0); chk("f2_rgb_edge", rgb_out, 0);
        run(5, 17, HT - 1); lines(6, 6); run(7, 0, 0);
        chk("f2_fc", frame_count, 1); chk("f2_locked", locked, 1);
        run(7, 1, HT - 1); lines(8, 9);
        // F3: tick held low mid-line
        lines(0, 2); run(3, 0, 9);
        chk("f3_px", pixel_x, 9); chk("f3_py", pixel_y, 3);
        idle(50);
        chk("hold_px", pixel_x, 9); chk("hold_py", pixel_y, 3);
        chk("hold_pv", pix_valid, 0); chk("hold_el", err_line, 0);
        run(3, 10, HT - 1); lines(4, 9);
        // F4: one short line
        lines(0, 3); run(4, 0, HT - 2); run(5, 0, HS0);
        chk("short_el", err_line, 1); chk("short_locked", locked, 0);
        chk("short_fc", frame_count, 2);
        run(5, HS0 + 1, HT - 1); lines(6, 9);
        // F5: relock, flag still sticky, then cleared
        lines(0, 6); run(7, 0, 0);
        chk("relock", locked, 1); chk("relock_el", err_line, 1);
        chk("relock_fc", frame_count, 2);
        clr_pulse();
        chk("clr_el", err_line, 0); chk("clr_locked", locked, 1);
        run(7, 1, HT - 1); lines(8, 9);
        // F6/F7: vsync three lines wide
        vs_w = 3;
        lines(0, 6); run(7, 0, 0);
        chk("f6_fc", frame_count, 3);
        run(7, 1, HT - 1); lines(8, 9);
        vs_w = VS;
        run(0, 0, 0);
        chk("vs_err", err_vs, 1); chk("vs_locked", locked, 0); chk("vs_fc", frame_count, 3);
        run(0, 1, HT - 1); lines(1, 9);
        // F8: relock
        lines(0, 6); run(7, 0, 0);
        chk("f8_locked", locked, 1);
        run(7, 1, HT - 1); lines(8, 9);
        // F9: reset at (10,3) with tick high
        lines(0, 2); run(3, 0, 10);
        @(negedge clk); reset = 1; tick = 1; hsync = 0; vsync = 0;
        @(posedge clk); #1;
        chk("mr_px", pixel_x, 0); chk("mr_py", pixel_y, 0); chk("mr_pv", pix_valid, 0);
        chk("mr_locked", locked, 0); chk("mr_fc", frame_count, 0);
        chk("mr_ev", err_vs, 0); chk("mr_vo", video_on, 0);
        @(negedge clk); reset = 0; tick = 0;
        run(3, 11, HT - 1); lines(4, 6); run(7, 0, 0);
        chk("mr_align", locked, 0);
        run(7, 1, HT - 1); lines(8, 9);
        lines(0, 6); run(7, 0, 0);
        chk("mr_relock", locked, 1); chk("mr_relock_fc", frame_count, 0);
        run(7, 1, HT - 1); lines(8, 9);
        // F11: wide hsync whose fall coincides with err_clr
        lines(0, 1); hs_w = 5; run(2, 0, HT - 2); hs_w = HS;
        do_tick(1'b0, vs_at(2), 1'b1);
        chk("hs_set_wins", err_hs, 1); chk("hs_locked", locked, 0);
        lines(3, 9);
        // F12: relock
        lines(0, 6); run(7, 0, 0);
        chk("f12_locked", locked, 1);
        run(7, 1, HT - 1); lines(8, 9);
        // F13: line of 1024+HT ticks must not alias onto HT
        lines(0, 2); run(3, 0, 1024 + HT - 1); run(4, 0, HS0);
        chk("sat_el", err_line, 1); chk("sat_locked", locked, 0);
        run(4, HS0 + 1, HT - 1);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
